pc_sequencer: RTL and testbench

Parametrised next-generation program-counter block for the RISC-V core. It holds the PC register and evaluates all six RV32I branch conditions internally. It computes JAL, JALR and branch targets and handles pipeline stall, trap entry and mret return. Misaligned control-flow targets are trapped, and it keeps a retired-instruction counter. It sits between decode/execute and instruction memory, and replaces the fixed 32-bit PC unit that relied on an external zero flag.

---
 rtl/pc_pkg.sv | 28 ++
 rtl/pc_sequencer_if.sv | 44 ++++
 rtl/branch_cond.sv | 36 +++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: shared types and constants for the program-counter sequencer.
//   state_e      : sequencer state (BOOT, RUN, FAULT)
//   F3_*         : RV32I conditional-branch funct3 encodings
//   INSTR_BYTES  : fixed instruction size used for the sequential step
//   align4()     : clears the two low bits of an address
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int INSTR_BYTES = 4;

  // Trap and mret addresses are always word-aligned by construction.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: control inputs and PC/status outputs of pc_sequencer.
//   master : decode/execute side (drives control, reads PC/status)
//   slave  : the sequencer itself
interface pc_sequencer_if #(
  parameter int XLEN      = 32,
  parameter int CNT_WIDTH = 64
);
  logic                 stall;
  logic                 branch;
  logic                 jump;
  logic                 jalr;
  logic [2:0]           funct3;
  logic [XLEN-1:0]      rs1_val;
  logic [XLEN-1:0]      rs2_val;
  logic [XLEN-1:0]      imm;
  logic                 trap_req;
  logic [XLEN-1:0]      trap_vector;
  logic                 mret;
  logic [XLEN-1:0]      mepc_in;

  logic [XLEN-1:0]      pc;
  logic [XLEN-1:0]      link_addr;
  logic                 fetch_valid;
  logic                 redirect;
  logic                 misaligned_fault;
  logic [XLEN-1:0]      fault_pc;
  logic [XLEN-1:0]      fault_addr;
  logic [CNT_WIDTH-1:0] instret;

  modport master (
    output stall, branch, jump, jalr, funct3, rs1_val, rs2_val, imm,
           trap_req, trap_vector, mret, mepc_in,
    input  pc, link_addr, fetch_valid, redirect, misaligned_fault,
           fault_pc, fault_addr, instret
  );

  modport slave (
    input  stall, branch, jump, jalr, funct3, rs1_val, rs2_val, imm,
           trap_req, trap_vector, mret, mepc_in,
    output pc, link_addr, fetch_valid, redirect, misaligned_fault,
           fault_pc, fault_addr, instret
  );

endinterface

// File: rtl/branch_cond.sv
// branch_cond: evaluates the RV32I conditional-branch predicate.
//   funct3_i : condition select (BEQ/BNE/BLT/BGE/BLTU/BGEU)
//   rs1_i    : operand A
//   rs2_i    : operand B
//   taken_o  : condition holds; reserved encodings 010/011 never take
module branch_cond
  import pc_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            taken_o
);

  logic eq, lt_s, lt_u;

  assign eq   = (rs1_i == rs2_i);
  assign lt_s = ($signed(rs1_i) < $signed(rs2_i));
  assign lt_u = (rs1_i < rs2_i);

  always_comb begin
    taken_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = eq;
      F3_BNE:  taken_o = !eq;
      F3_BLT:  taken_o = lt_s;
      F3_BGE:  taken_o = !lt_s;
      F3_BLTU: taken_o = lt_u;
      F3_BGEU: taken_o = !lt_u;
      default: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: PC register, next-PC selection, misaligned-target trapping
// and retired-instruction counter.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : pc_sequencer_if slave (control in, pc/link/status out)
// Next-PC priority in RUN: trap > mret > stall > jalr > jump > branch > +4.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              CNT_WIDTH    = 64
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  state_e               state_q, state_d;
  logic [XLEN-1:0]      pc_q, pc_d;
  logic                 flt_q, flt_d;
  logic [XLEN-1:0]      fault_pc_q, fault_pc_d;
  logic [XLEN-1:0]      fault_addr_q, fault_addr_d;
  logic [CNT_WIDTH-1:0] instret_q, instret_d;

  logic            taken;
  logic            cf_sel;
  logic [XLEN-1:0] br_tgt, jalr_tgt, cf_tgt;
  logic [XLEN-1:0] trap_tgt, mret_tgt;
  logic            retire;
  logic            redirect_c;

  branch_cond #(.XLEN(XLEN)) u_branch_cond (
    .funct3_i (bus.funct3),
    .rs1_i    (bus.rs1_val),
    .rs2_i    (bus.rs2_val),
    .taken_o  (taken)
  );

  assign br_tgt   = pc_q + bus.imm;
  assign jalr_tgt = (bus.rs1_val + bus.imm) & ~XLEN'(1);
  assign trap_tgt = bus.trap_vector & ~XLEN'(3);
  assign mret_tgt = bus.mepc_in & ~XLEN'(3);

  // jalr outranks jump, which outranks a taken branch.
  assign cf_sel = bus.jalr | bus.jump | (bus.branch & taken);
  assign cf_tgt = bus.jalr ? jalr_tgt : br_tgt;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flt_d        = 1'b0;
    fault_pc_d   = fault_pc_q;
    fault_addr_d = fault_addr_q;
    retire       = 1'b0;
    redirect_c   = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (bus.trap_req) begin
          pc_d       = trap_tgt;
          redirect_c = 1'b1;
        end else if (bus.mret) begin
          pc_d       = mret_tgt;
          redirect_c = 1'b1;
          retire     = 1'b1;
        end else if (bus.stall) begin
          // PC held; target is not checked while stalled.
        end else if (cf_sel) begin
          if (cf_tgt[1]) begin
            // Misaligned: hold PC, capture context, park in FAULT.
            flt_d        = 1'b1;
            fault_pc_d   = pc_q;
            fault_addr_d = cf_tgt;
            state_d      = FAULT;
          end else begin
            pc_d       = cf_tgt;
            redirect_c = 1'b1;
            retire     = 1'b1;
          end
        end else begin
          pc_d   = pc_q + XLEN'(INSTR_BYTES);
          retire = 1'b1;
        end
      end
      FAULT: begin
        // Only a trap leaves FAULT; everything else is ignored.
        if (bus.trap_req) begin
          pc_d    = trap_tgt;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  assign instret_d = retire ? instret_q + CNT_WIDTH'(1) : instret_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc_q         <= RESET_VECTOR;
      flt_q        <= 1'b0;
      fault_pc_q   <= '0;
      fault_addr_q <= '0;
      instret_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flt_q        <= flt_d;
      fault_pc_q   <= fault_pc_d;
      fault_addr_q <= fault_addr_d;
      instret_q    <= instret_d;
    end
  end

  assign bus.pc               = pc_q;
  assign bus.link_addr        = pc_q + XLEN'(INSTR_BYTES);
  assign bus.fetch_valid      = (state_q == RUN);
  assign bus.redirect         = redirect_c;
  assign bus.misaligned_fault = flt_q;
  assign bus.fault_pc         = fault_pc_q;
  assign bus.fault_addr       = fault_addr_q;
  assign bus.instret          = instret_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic rst_b;

  always #5 clk = ~clk;

  pc_sequencer_if #(.XLEN(32), .CNT_WIDTH(64)) bus ();
  pc_sequencer_if #(.XLEN(32), .CNT_WIDTH(4))  bus_b ();

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h100), .CNT_WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  pc_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0), .CNT_WIDTH(4)) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .bus   (bus_b)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [63:0] ir;

  function automatic void push(input string tag, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endfunction

  task automatic chk(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=0x%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.stall = 0; bus.branch = 0; bus.jump = 0; bus.jalr = 0;
    bus.funct3 = 0; bus.rs1_val = 0; bus.rs2_val = 0; bus.imm = 0;
    bus.trap_req = 0; bus.trap_vector = 0; bus.mret = 0; bus.mepc_in = 0;
  endtask

  // Load PC directly through a trap (trap does not retire).
  task automatic load_pc(input logic [31:0] a);
    clr();
    bus.trap_req = 1; bus.trap_vector = a;
    step();
    bus.trap_req = 0;
  endtask

  initial begin
    bus_b.stall = 0; bus_b.branch = 0; bus_b.jump = 0; bus_b.jalr = 0;
    bus_b.funct3 = 0; bus_b.rs1_val = 0; bus_b.rs2_val = 0; bus_b.imm = 0;
    bus_b.trap_req = 0; bus_b.trap_vector = 0; bus_b.mret = 0; bus_b.mepc_in = 0;
    rst_b = 1;
    reset = 1;
    clr();
    repeat (2) step();

    // 1: reset values, BOOT cycle, sequential stepping
    push("rst_pc", 64'h100); push("rst_fv", 0); push("rst_ir", 0);
    push("rst_mf", 0); push("rst_fpc", 0); push("rst_fad", 0);
    chk(64'(bus.pc)); chk(64'(bus.fetch_valid)); chk(bus.instret);
    chk(64'(bus.misaligned_fault)); chk(64'(bus.fault_pc)); chk(64'(bus.fault_addr));
    reset = 0;
    #1;
    push("boot_fv", 0); chk(64'(bus.fetch_valid));
    push("boot_pc", 64'h100); push("run_fv", 1); push("link", 64'h104);
    step();
    chk(64'(bus.pc)); chk(64'(bus.fetch_valid)); chk(64'(bus.link_addr));
    push("seq_pc1", 64'h104); step(); chk(64'(bus.pc));
    push("seq_pc2", 64'h108); push("seq_ir2", 2); step();
    chk(64'(bus.pc)); chk(bus.instret);
    ir = 2;

    // 2: signed vs unsigned branch, plus other conditions
    load_pc(32'h200);
    push("trap_ir", ir); chk(bus.instret);
    bus.branch = 1; bus.funct3 = F3_BLT; bus.imm = 32'hFFFF_FFF8;
    bus.rs1_val = 32'hFFFF_FFFF; bus.rs2_val = 32'h1;
    #1; push("blt_redir", 1); chk(64'(bus.redirect));
    ir++; push("blt_pc", 64'h1F8); push("blt_ir", ir);
    step(); chk(64'(bus.pc)); chk(bus.instret);
    load_pc(32'h200);
    bus.branch = 1; bus.funct3 = F3_BLTU; bus.imm = 32'hFFFF_FFF8;
    bus.rs1_val = 32'hFFFF_FFFF; bus.rs2_val = 32'h1;
    #1; push("bltu_redir", 0); chk(64'(bus.redirect));
    ir++; push("bltu_pc", 64'h204); step(); chk(64'(bus.pc));
    bus.funct3 = F3_BGE; bus.imm = 32'h10; bus.rs1_val = 5; bus.rs2_val = 5;
    ir++; push("bge_pc", 64'h214); step(); chk(64'(bus.pc));
    bus.funct3 = 3'b010;
    ir++; push("f3_010_pc", 64'h218); step(); chk(64'(bus.pc));
    bus.funct3 = F3_BNE;
    ir++; push("bne_pc", 64'h21C); step(); chk(64'(bus.pc));
    bus.funct3 = F3_BEQ; bus.imm = 32'hFFFF_FFE4;
    ir++; push("beq_pc", 64'h200); push("beq_ir", ir);
    step(); chk(64'(bus.pc)); chk(bus.instret);

    // 3: misaligned JALR fault, FAULT ignores controls, trap recovers
    load_pc(32'h40);
    bus.jalr = 1; bus.rs1_val = 32'h1001; bus.imm = 32'h2;
    #1; push("jalr_flt_redir", 0); chk(64'(bus.redirect));
    push("flt_pc", 64'h40); push("flt_mf", 1); push("flt_fpc", 64'h40);
    push("flt_fad", 64'h1002); push("flt_fv", 0); push("flt_ir", ir);
    step();
    chk(64'(bus.pc)); chk(64'(bus.misaligned_fault)); chk(64'(bus.fault_pc));
    chk(64'(bus.fault_addr)); chk(64'(bus.fetch_valid)); chk(bus.instret);
    clr();
    bus.jump = 1; bus.stall = 1; bus.mret = 1; bus.imm = 32'h8; bus.mepc_in = 32'h500;
    push("fhold_pc", 64'h40); push("fhold_mf", 0); push("fhold_fv", 0);
    step(); chk(64'(bus.pc)); chk(64'(bus.misaligned_fault)); chk(64'(bus.fetch_valid));
    clr();
    bus.trap_req = 1; bus.trap_vector = 32'h800;
    #1; push("ftrap_redir", 0); chk(64'(bus.redirect));
    push("ftrap_pc", 64'h800); push("ftrap_fv", 1); push("ftrap_ir", ir);
    step(); chk(64'(bus.pc)); chk(64'(bus.fetch_valid)); chk(bus.instret);

    // 4: trap beats stall and a misaligned jump; vector low bits dropped
    clr();
    bus.jump = 1; bus.stall = 1; bus.trap_req = 1;
    bus.trap_vector = 32'h8000_0003; bus.imm = 32'h2;
    push("t4_pc", 64'h8000_0000); push("t4_ir", ir); push("t4_mf", 0);
    step(); chk(64'(bus.pc)); chk(bus.instret); chk(64'(bus.misaligned_fault));

    // 5: stall (with a misaligned jump pending) then mret
    clr();
    bus.stall = 1; bus.jump = 1; bus.imm = 32'h2;
    for (int i = 0; i < 3; i++) begin
      #1; push("stall_redir", 0); chk(64'(bus.redirect));
      push("stall_pc", 64'h8000_0000); push("stall_ir", ir); push("stall_mf", 0);
      step(); chk(64'(bus.pc)); chk(bus.instret); chk(64'(bus.misaligned_fault));
    end
    clr();
    bus.mret = 1; bus.mepc_in = 32'h3C; bus.branch = 1; bus.funct3 = F3_BEQ;
    bus.imm = 32'h40;
    #1; push("mret_redir", 1); chk(64'(bus.redirect));
    ir++; push("mret_pc", 64'h3C); push("mret_ir", ir);
    step(); chk(64'(bus.pc)); chk(bus.instret);

    // 6: reset from FAULT; counter wrap on the narrow instance
    clr();
    bus.jump = 1; bus.imm = 32'h6;
    push("j_flt_mf", 1); push("j_flt_fad", 64'h42); push("j_flt_fv", 0);
    step(); chk(64'(bus.misaligned_fault)); chk(64'(bus.fault_addr)); chk(64'(bus.fetch_valid));
    clr();
    reset = 1;
    push("frst_pc", 64'h100); push("frst_fv", 0); push("frst_ir", 0);
    push("frst_mf", 0); push("frst_fad", 0);
    step();
    chk(64'(bus.pc)); chk(64'(bus.fetch_valid)); chk(bus.instret);
    chk(64'(bus.misaligned_fault)); chk(64'(bus.fault_addr));
    reset = 0;
    push("frst_boot_pc", 64'h100); push("frst_boot_fv", 1);
    step(); chk(64'(bus.pc)); chk(64'(bus.fetch_valid));

    rst_b = 0;
    step();
    repeat (15) step();
    push("wrap_ir15", 15); push("wrap_pc15", 64'h3C);
    chk(64'(bus_b.instret)); chk(64'(bus_b.pc));
    push("wrap_ir0", 0); push("wrap_pc16", 64'h40);
    step(); chk(64'(bus_b.instret)); chk(64'(bus_b.pc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
